// File: rtl/uart_rx_byte_fifo.sv
// Receive byte buffer: FWFT FIFO turning un-throttled UART byte pulses into an AXIS byte stream.
// Latency: a byte pulsed in cycle N is presented on m_axis in cycle N+1.
// Backpressure: none upstream; a byte arriving while full with no read that cycle is dropped and counted.
module uart_rx_byte_fifo #(
    parameter int fifo_depth       = 16,
    parameter int timeout_clk_n    = 17360,
    parameter int simulation_delay = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    s_byte_data,
    input  logic                          s_byte_valid,
    output logic [7:0]                    m_axis_data,
    output logic                          m_axis_valid,
    input  logic                          m_axis_ready,
    output logic [$clog2(fifo_depth):0]   fifo_cnt,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    input  logic [$clog2(fifo_depth):0]   thresh,
    output logic                          thresh_reached,
    output logic                          ovf_flag,
    output logic [7:0]                    ovf_cnt,
    input  logic                          ovf_clr,
    output logic                          timeout_pulse
);

    localparam int AW = $clog2(fifo_depth);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(timeout_clk_n);
    localparam logic [CW-1:0] DEPTH   = CW'(fifo_depth);
    localparam logic [TW-1:0] TMO_MAX = TW'(timeout_clk_n - 1);
    localparam logic [TW-1:0] TMO_PRE = TW'(timeout_clk_n - 2);

    // Register updates are zero-delay; simulation_delay is accepted only for drop-in compatibility.
    if (simulation_delay < 0) begin : g_negative_sim_delay
    end

    logic [7:0]    mem [fifo_depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_next;
    logic [TW-1:0] tmo_cnt;
    logic          wr_en;
    logic          rd_en;
    logic          drop;
    logic          tmo_clr;
    logic          tmo_inc;

    assign fifo_empty   = (fifo_cnt == '0);
    assign fifo_full    = (fifo_cnt == DEPTH);
    assign m_axis_valid = !fifo_empty;
    assign m_axis_data  = mem[rd_ptr];

    assign rd_en   = m_axis_valid && m_axis_ready;
    assign wr_en   = s_byte_valid && (!fifo_full || rd_en);
    assign drop    = s_byte_valid && !wr_en;
    assign tmo_clr = wr_en || rd_en || fifo_empty;
    assign tmo_inc = !tmo_clr && (tmo_cnt != TMO_MAX);

    always_comb begin
        cnt_next = fifo_cnt;
        if (wr_en && !rd_en) begin
            cnt_next = fifo_cnt + CW'(1);
        end else if (rd_en && !wr_en) begin
            cnt_next = fifo_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s_byte_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            thresh_reached <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_cnt       <= cnt_next;
            thresh_reached <= (thresh != '0) && (cnt_next >= thresh);
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
        end else if (drop) begin
            ovf_flag <= 1'b1;
            if (ovf_clr) begin
                ovf_cnt <= 8'd1;
            end else if (ovf_cnt != 8'hFF) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
        end else if (ovf_clr) begin
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
        end
    end

    // The pulse is raised on the single increment that lands on the terminal value, so a held counter never re-fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt       <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            if (tmo_clr) begin
                tmo_cnt <= '0;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            timeout_pulse <= tmo_inc && (tmo_cnt == TMO_PRE);
        end
    end

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Bench for uart_rx_byte_fifo at depth 4 and a 20-clock idle timeout.
// Expected bytes are queued at stimulus time and popped by an independent output monitor.
module tb_uart_rx_byte_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_byte_data;
    logic       s_byte_valid;
    logic [7:0] m_axis_data;
    logic       m_axis_valid;
    logic       m_axis_ready;
    logic [2:0] fifo_cnt;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] thresh;
    logic       thresh_reached;
    logic       ovf_flag;
    logic [7:0] ovf_cnt;
    logic       ovf_clr;
    logic       timeout_pulse;

    int         n_vec;
    int         n_err;
    int         tmo_seen;
    int         base;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_rx_byte_fifo #(
        .fifo_depth      (4),
        .timeout_clk_n   (20),
        .simulation_delay(1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_byte_data   (s_byte_data),
        .s_byte_valid  (s_byte_valid),
        .m_axis_data   (m_axis_data),
        .m_axis_valid  (m_axis_valid),
        .m_axis_ready  (m_axis_ready),
        .fifo_cnt      (fifo_cnt),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .thresh        (thresh),
        .thresh_reached(thresh_reached),
        .ovf_flag      (ovf_flag),
        .ovf_cnt       (ovf_cnt),
        .ovf_clr       (ovf_clr),
        .timeout_pulse (timeout_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] b, input bit acc);
        if (acc) exp_q.push_back(b);
        s_byte_data  = b;
        s_byte_valid = 1'b1;
        step(1);
        s_byte_valid = 1'b0;
    endtask

    // Output monitor: every handshake must deliver the oldest outstanding expected byte.
    initial begin
        tmo_seen = 0;
        forever begin
            @(negedge clk);
            if (timeout_pulse) tmo_seen++;
            if (rst_n && m_axis_valid && m_axis_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_byte", int'(m_axis_data), -1);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("sb_data", int'(m_axis_data), int'(exp_b));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        s_byte_data  = 8'h00;
        s_byte_valid = 1'b0;
        m_axis_ready = 1'b0;
        thresh       = 3'd0;
        ovf_clr      = 1'b0;
        step(2);
        check("rst_cnt", fifo_cnt, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_valid", m_axis_valid, 0);
        check("rst_thresh", thresh_reached, 0);
        check("rst_ovf_flag", ovf_flag, 0);
        check("rst_ovf_cnt", ovf_cnt, 0);
        check("rst_tmo", timeout_pulse, 0);
        rst_n = 1'b1;
        step(1);

        // Basic ordering
        wr(8'h55, 1);
        check("lat_valid", m_axis_valid, 1);
        check("lat_cnt", fifo_cnt, 1);
        wr(8'hA3, 1);
        wr(8'h0F, 1);
        check("ord_cnt", fifo_cnt, 3);
        check("ord_head", m_axis_data, 8'h55);
        step(2);
        check("stall_head", m_axis_data, 8'h55);
        check("stall_valid", m_axis_valid, 1);
        m_axis_ready = 1'b1;
        step(3);
        m_axis_ready = 1'b0;
        check("ord_empty", fifo_empty, 1);
        check("ord_valid", m_axis_valid, 0);

        // Overflow
        for (int i = 1; i <= 4; i++) wr(8'(i), 1);
        check("ovf_full", fifo_full, 1);
        check("ovf_cnt4", fifo_cnt, 4);
        wr(8'h05, 0);
        check("ovf_flag_set", ovf_flag, 1);
        check("ovf_cnt_1", ovf_cnt, 1);
        check("ovf_fifo_cnt", fifo_cnt, 4);
        check("ovf_head", m_axis_data, 8'h01);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("ovf_clr_flag", ovf_flag, 0);
        check("ovf_clr_cnt", ovf_cnt, 0);
        ovf_clr = 1'b1;
        wr(8'h06, 0);
        ovf_clr = 1'b0;
        check("ovf_coinc_flag", ovf_flag, 1);
        check("ovf_coinc_cnt", ovf_cnt, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("ovf_reclr_cnt", ovf_cnt, 0);

        // Full with simultaneous write and read
        m_axis_ready = 1'b1;
        wr(8'h09, 1);
        m_axis_ready = 1'b0;
        check("fwr_cnt", fifo_cnt, 4);
        check("fwr_full", fifo_full, 1);
        check("fwr_ovf", ovf_flag, 0);
        check("fwr_head", m_axis_data, 8'h02);
        m_axis_ready = 1'b1;
        step(4);
        m_axis_ready = 1'b0;
        check("fwr_empty", fifo_empty, 1);

        // Wrap-around streaming
        m_axis_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr(8'(16 + i), 1);
            check("wrap_cnt", fifo_cnt, 1);
        end
        step(1);
        m_axis_ready = 1'b0;
        check("wrap_empty", fifo_empty, 1);

        // Timeout: single byte, pulse exactly 20 cycles after the write cycle
        base = tmo_seen;
        wr(8'h77, 1);
        for (int k = 1; k <= 25; k++) begin
            check("tmo_pulse", timeout_pulse, int'(k == 20));
            step(1);
        end
        step(10);
        check("tmo_once", tmo_seen - base, 1);
        m_axis_ready = 1'b1;
        step(1);
        m_axis_ready = 1'b0;

        // Timeout restart by a second write 10 cycles later
        base = tmo_seen;
        wr(8'h88, 1);
        for (int k = 1; k <= 35; k++) begin
            check("tmo_restart", timeout_pulse, int'(k == 30));
            if (k == 10) wr(8'h89, 1);
            else step(1);
        end
        check("tmo_restart_once", tmo_seen - base, 1);
        m_axis_ready = 1'b1;
        step(2);
        m_axis_ready = 1'b0;
        base = tmo_seen;
        step(30);
        check("tmo_empty_none", tmo_seen - base, 0);

        // Threshold
        thresh = 3'd3;
        wr(8'hA1, 1);
        wr(8'hA2, 1);
        check("thr_below", thresh_reached, 0);
        wr(8'hA3, 1);
        check("thr_reached", thresh_reached, 1);
        check("thr_cnt", fifo_cnt, 3);
        m_axis_ready = 1'b1;
        step(1);
        m_axis_ready = 1'b0;
        check("thr_drop", thresh_reached, 0);
        check("thr_cnt2", fifo_cnt, 2);
        thresh = 3'd0;
        wr(8'hA4, 1);
        check("thr_dis3", thresh_reached, 0);
        wr(8'hA5, 1);
        check("thr_dis4", thresh_reached, 0);
        check("thr_cnt4", fifo_cnt, 4);
        m_axis_ready = 1'b1;
        step(2);
        m_axis_ready = 1'b0;
        check("pre_rst_cnt", fifo_cnt, 2);

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #2;
        check("arst_cnt", fifo_cnt, 0);
        check("arst_valid", m_axis_valid, 0);
        check("arst_empty", fifo_empty, 1);
        exp_q.delete();
        step(1);
        rst_n = 1'b1;
        step(2);
        check("post_rst_cnt", fifo_cnt, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
